// File: rtl/cmd_sched_pkg.sv
// cmd_sched_pkg: shared definitions for the command scheduler.
// Holds the wireless opcodes, the response bytes and the scheduler state type.
// The scheduler RTL and its bench both import this package.
package cmd_sched_pkg;

  // Opcodes
  localparam logic [7:0] REQ_BATT  = 8'h01;
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;

  // Response bytes
  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  typedef enum logic [2:0] {
    StIdle,
    StBatt,
    StSpin,
    StCal,
    StResp,
    StRespWait
  } sched_state_t;

endpackage

// File: rtl/cmd_sched_sat_timer.sv
// sat_timer: saturating up-counter.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears the count
//   clr  - synchronous clear
//   en   - count enable; counting stops once the count is all-ones
//   full - high while the count is all-ones
module sat_timer #(
  parameter int unsigned Width = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic full
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && !full) begin
      cnt_q <= cnt_q + {{(Width - 1){1'b0}}, 1'b1};
    end
  end

  assign full = &cnt_q;

endmodule

// File: rtl/cmd_sched.sv
// cmd_sched: command scheduler between the UART command receiver and the
// flight datapath. Decodes commands, owns the flight setpoints and motor kill,
// runs the battery-read and spin-up/calibrate sequences and issues one
// response byte per command. A watchdog zeroes the setpoints when the link
// goes quiet.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   cmd_rdy, cmd, data       - command frame from the receiver
//   clr_cmd_rdy              - pulse consuming the frame
//   resp, send_resp          - response byte and transmit start pulse
//   resp_sent                - transmitter finished
//   strt_cnv, cnv_cmplt, batt- battery A2D handshake and reading
//   strt_cal, cal_done       - inertial calibration handshake
//   motors_off               - motor kill
//   d_ptch, d_roll, d_yaw    - signed attitude setpoints
//   thrst                    - unsigned thrust setpoint
module cmd_sched
  import cmd_sched_pkg::*;
#(
  parameter int unsigned WD_W   = 26,
  parameter int unsigned SPIN_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_rdy,
  input  logic [7:0]         cmd,
  input  logic [15:0]        data,
  output logic               clr_cmd_rdy,
  output logic [7:0]         resp,
  output logic               send_resp,
  input  logic               resp_sent,
  output logic               strt_cnv,
  input  logic               cnv_cmplt,
  input  logic [7:0]         batt,
  output logic               strt_cal,
  input  logic               cal_done,
  output logic               motors_off,
  output logic signed [15:0] d_ptch,
  output logic signed [15:0] d_roll,
  output logic signed [15:0] d_yaw,
  output logic [8:0]         thrst
);

  sched_state_t state_q, state_d;
  logic [7:0]   resp_q, resp_d;
  logic         motors_off_q, motors_off_d;
  logic [15:0]  ptch_q, ptch_d;
  logic [15:0]  roll_q, roll_d;
  logic [15:0]  yaw_q, yaw_d;
  logic [8:0]   thrst_q, thrst_d;

  logic accept;
  logic spin_clr;
  logic wd_full;
  logic spin_full;

  // Pulses are masked during reset so none escape while the FSM is being forced.
  assign accept      = (state_q == StIdle) && cmd_rdy && !rst;
  assign clr_cmd_rdy = accept;
  assign strt_cnv    = accept && (cmd == REQ_BATT);
  assign strt_cal    = (state_q == StSpin) && spin_full && !rst;
  assign send_resp   = (state_q == StResp) && !rst;

  sat_timer #(
    .Width (WD_W)
  ) u_wd_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (1'b1),
    .full (wd_full)
  );

  sat_timer #(
    .Width (SPIN_W)
  ) u_spin_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (spin_clr),
    .en   (state_q == StSpin),
    .full (spin_full)
  );

  always_comb begin
    state_d      = state_q;
    resp_d       = resp_q;
    motors_off_d = motors_off_q;
    ptch_d       = ptch_q;
    roll_d       = roll_q;
    yaw_d        = yaw_q;
    thrst_d      = thrst_q;
    spin_clr     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_rdy) begin
          case (cmd)
            SET_PTCH: begin
              ptch_d  = data;
              resp_d  = ACK;
              state_d = StResp;
            end
            SET_ROLL: begin
              roll_d  = data;
              resp_d  = ACK;
              state_d = StResp;
            end
            SET_YAW: begin
              yaw_d   = data;
              resp_d  = ACK;
              state_d = StResp;
            end
            SET_THRST: begin
              thrst_d = data[8:0];
              resp_d  = ACK;
              state_d = StResp;
            end
            EMER_LAND: begin
              ptch_d  = '0;
              roll_d  = '0;
              yaw_d   = '0;
              thrst_d = '0;
              resp_d  = ACK;
              state_d = StResp;
            end
            MTRS_OFF: begin
              motors_off_d = 1'b1;
              resp_d       = ACK;
              state_d      = StResp;
            end
            REQ_BATT: begin
              state_d = StBatt;
            end
            CALIBRATE: begin
              motors_off_d = 1'b0;
              ptch_d       = '0;
              roll_d       = '0;
              yaw_d        = '0;
              thrst_d      = '0;
              spin_clr     = 1'b1;
              state_d      = StSpin;
            end
            default: begin
              resp_d  = NAK;
              state_d = StResp;
            end
          endcase
        end
      end
      StBatt: begin
        if (cnv_cmplt) begin
          resp_d  = batt;
          state_d = StResp;
        end
      end
      StSpin: begin
        if (spin_full) begin
          state_d = StCal;
        end
      end
      StCal: begin
        if (cal_done) begin
          resp_d  = ACK;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StRespWait;
      end
      StRespWait: begin
        if (resp_sent) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Link-loss landing; a command accepted this cycle takes precedence since
    // it also restarts the watchdog.
    if (wd_full && !accept) begin
      ptch_d  = '0;
      roll_d  = '0;
      yaw_d   = '0;
      thrst_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      resp_q       <= 8'h00;
      motors_off_q <= 1'b1;
      ptch_q       <= '0;
      roll_q       <= '0;
      yaw_q        <= '0;
      thrst_q      <= '0;
    end else begin
      state_q      <= state_d;
      resp_q       <= resp_d;
      motors_off_q <= motors_off_d;
      ptch_q       <= ptch_d;
      roll_q       <= roll_d;
      yaw_q        <= yaw_d;
      thrst_q      <= thrst_d;
    end
  end

  assign resp       = resp_q;
  assign motors_off = motors_off_q;
  assign d_ptch     = ptch_q;
  assign d_roll     = roll_q;
  assign d_yaw      = yaw_q;
  assign thrst      = thrst_q;

endmodule
